// File: rtl/csr_trap_ctrl_if.sv
// Commit-stage bundle between the execute pipeline and the machine-mode CSR/trap block.
// valid marks one instruction per cycle and has no ready: the block never stalls, so the
// instruction commits that cycle unless raise_trap reports a trap (an MRET redirect still commits).
interface csr_trap_ctrl_if #(
  parameter int XLEN    = 64,
  parameter int NUM_HPM = 4
);
  localparam int HPM_W = (NUM_HPM < 1) ? 1 : NUM_HPM;

  logic             valid;
  logic [XLEN-1:0]  pc;
  logic [31:0]      inst_bits;
  logic             is_csr;
  logic [2:0]       funct3;
  logic             is_mret;
  logic [11:0]      csr_addr;
  logic [4:0]       rs1_addr;
  logic [XLEN-1:0]  rs1_data;
  logic             expt_valid;
  logic [XLEN-1:0]  expt_cause;
  logic [XLEN-1:0]  expt_value;
  logic             retire;
  logic [HPM_W-1:0] hpm_event;
  logic             irq_meip;
  logic             irq_msip;
  logic             irq_mtip;
  logic [XLEN-1:0]  rdata;
  logic             raise_trap;
  logic [XLEN-1:0]  trap_vector;
  logic             trap_return;

  modport master (
    output valid, pc, inst_bits, is_csr, funct3, is_mret, csr_addr, rs1_addr, rs1_data,
           expt_valid, expt_cause, expt_value, retire, hpm_event, irq_meip, irq_msip, irq_mtip,
    input  rdata, raise_trap, trap_vector, trap_return
  );

  modport slave (
    input  valid, pc, inst_bits, is_csr, funct3, is_mret, csr_addr, rs1_addr, rs1_data,
           expt_valid, expt_cause, expt_value, retire, hpm_event, irq_meip, irq_msip, irq_mtip,
    output rdata, raise_trap, trap_vector, trap_return
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap controller: Zicsr decode, MRET, exceptions, three
// machine interrupts, vectored mtvec, 64-bit counters with mcountinhibit.
module csr_trap_ctrl #(
  parameter int              XLEN        = 64,
  parameter int              NUM_HPM     = 4,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input logic            clk,
  input logic            rst,
  csr_trap_ctrl_if.slave bus
);
  localparam int HPM_W = (NUM_HPM < 1) ? 1 : NUM_HPM;
  localparam logic [31:0] CINH_MASK = 32'(((64'd1 << (3 + NUM_HPM)) - 64'd1) & ~64'd2);
  localparam logic [XLEN-1:0] MISA = (XLEN'((XLEN == 64) ? 2 : 1) << (XLEN - 2)) | XLEN'(1 << 8);

  // Interrupt bits are kept packed as {MEI, MTI, MSI}.
  logic            mst_mie, mst_mpie;
  logic [2:0]      mie_q, mip_q;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [31:0]     cinh_q;
  logic [63:0]     mcycle_q, minstret_q;
  logic [63:0]     hpm_q [HPM_W];

  function automatic logic [XLEN-1:0] irq_bits(input logic [2:0] b);
    irq_bits     = '0;
    irq_bits[11] = b[2];
    irq_bits[7]  = b[1];
    irq_bits[3]  = b[0];
  endfunction

  logic [1:0]      op;
  logic [XLEN-1:0] src, wdata, csr_val, mstatus_rd, mtvec_base, cause, tval;
  logic            wr_intent, csr_ok, cnt_lo, cnt_hi, cnt_ok;
  logic [4:0]      cidx;
  logic [63:0]     cnt_sel, cnt_new, wd64;
  logic [2:0]      pend;
  logic [3:0]      irq_code;
  logic            irq_take, illegal, exc_take, trap, mret_take, csr_we;

  assign op         = bus.funct3[1:0];
  assign src        = bus.funct3[2] ? XLEN'(bus.rs1_addr) : bus.rs1_data;
  assign wr_intent  = (op == 2'b01) || (bus.rs1_addr != 5'd0);
  assign cidx       = bus.csr_addr[4:0];
  assign cnt_lo     = (bus.csr_addr[11:5] == 7'b1011000);
  assign cnt_hi     = (XLEN == 32) && (bus.csr_addr[11:5] == 7'b1011100);
  assign mstatus_rd = XLEN'({2'b11, 3'b000, mst_mpie, 3'b000, mst_mie, 3'b000});
  assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    cnt_sel = '0;
    cnt_ok  = 1'b0;
    if (cidx == 5'd0) begin
      cnt_sel = mcycle_q;
      cnt_ok  = 1'b1;
    end else if (cidx == 5'd2) begin
      cnt_sel = minstret_q;
      cnt_ok  = 1'b1;
    end
    for (int i = 0; i < NUM_HPM; i++) begin
      if (cidx == 5'(i + 3)) begin
        cnt_sel = hpm_q[i];
        cnt_ok  = 1'b1;
      end
    end
  end

  always_comb begin
    csr_ok  = 1'b1;
    csr_val = '0;
    case (bus.csr_addr)
      12'h300: csr_val = mstatus_rd;
      12'h301: csr_val = MISA;
      12'h304: csr_val = irq_bits(mie_q);
      12'h305: csr_val = mtvec_q;
      12'h320: csr_val = XLEN'(cinh_q);
      12'h340: csr_val = mscratch_q;
      12'h341: csr_val = mepc_q;
      12'h342: csr_val = mcause_q;
      12'h343: csr_val = mtval_q;
      12'h344: csr_val = irq_bits(mip_q);
      12'hF11, 12'hF12, 12'hF13: csr_val = '0;
      12'hF14: csr_val = HART_ID;
      default: begin
        csr_ok = (cnt_lo || cnt_hi) && cnt_ok;
        if (csr_ok) csr_val = cnt_hi ? XLEN'(cnt_sel >> 32) : XLEN'(cnt_sel);
      end
    endcase
  end

  always_comb begin
    case (op)
      2'b01:   wdata = src;
      2'b10:   wdata = csr_val | src;
      default: wdata = csr_val & ~src;
    endcase
  end

  // A 32-bit write to one counter half keeps the other half intact.
  assign wd64    = 64'(wdata);
  assign cnt_new = cnt_hi ? {wd64[31:0], cnt_sel[31:0]} :
                   (XLEN == 32) ? {cnt_sel[63:32], wd64[31:0]} : wd64;

  assign pend      = mip_q & mie_q;
  assign irq_code  = pend[2] ? 4'd11 : (pend[0] ? 4'd3 : 4'd7);
  assign irq_take  = bus.valid && mst_mie && (pend != 3'b000);
  assign illegal   = bus.is_csr && (!csr_ok || (op == 2'b00) ||
                                    (wr_intent && (bus.csr_addr[11:10] == 2'b11)));
  assign exc_take  = bus.valid && !irq_take && (bus.expt_valid || illegal);
  assign trap      = irq_take || exc_take;
  assign mret_take = bus.valid && bus.is_mret && !trap;
  assign csr_we    = bus.valid && !trap && bus.is_csr && wr_intent;

  assign cause = irq_take ? {1'b1, {(XLEN-5){1'b0}}, irq_code} :
                 (bus.expt_valid ? bus.expt_cause : XLEN'(2));
  assign tval  = irq_take ? '0 : (bus.expt_valid ? bus.expt_value : XLEN'(bus.inst_bits));

  assign bus.rdata       = csr_val;
  assign bus.raise_trap  = !rst && (trap || mret_take);
  assign bus.trap_return = !rst && mret_take;
  assign bus.trap_vector = mret_take ? mepc_q :
                           (irq_take && mtvec_q[0]) ? mtvec_base + XLEN'({irq_code, 2'b00}) :
                           mtvec_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= MTVEC_RESET & ~XLEN'(3);
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      cinh_q     <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      for (int i = 0; i < HPM_W; i++) hpm_q[i] <= '0;
    end else begin
      mip_q <= {bus.irq_meip, bus.irq_mtip, bus.irq_msip};
      if (!cinh_q[0]) mcycle_q <= mcycle_q + 64'd1;
      if (!cinh_q[2] && bus.valid && bus.retire && !(trap || mret_take))
        minstret_q <= minstret_q + 64'd1;
      for (int i = 0; i < NUM_HPM; i++)
        if (!cinh_q[i + 3] && bus.hpm_event[i]) hpm_q[i] <= hpm_q[i] + 64'd1;

      if (trap) begin
        mepc_q   <= {bus.pc[XLEN-1:1], 1'b0};
        mcause_q <= cause;
        mtval_q  <= tval;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (mret_take) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (csr_we) begin
        case (bus.csr_addr)
          12'h300: begin
            mst_mie  <= wdata[3];
            mst_mpie <= wdata[7];
          end
          12'h304: mie_q      <= {wdata[11], wdata[7], wdata[3]};
          12'h305: mtvec_q    <= wdata & ~XLEN'(2);
          12'h320: cinh_q     <= 32'(wdata) & CINH_MASK;
          12'h340: mscratch_q <= wdata;
          12'h341: mepc_q     <= wdata & ~XLEN'(1);
          12'h342: mcause_q   <= wdata;
          12'h343: mtval_q    <= wdata;
          default: ;
        endcase
        // Counter writes land after the increments above so the write wins.
        if (cnt_lo || cnt_hi) begin
          if (cidx == 5'd0) mcycle_q <= cnt_new;
          else if (cidx == 5'd2) minstret_q <= cnt_new;
          for (int i = 0; i < NUM_HPM; i++)
            if (cidx == 5'(i + 3)) hpm_q[i] <= cnt_new;
        end
      end
    end
  end
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: a 64-bit instance for traps/CSRs and a 32-bit instance for split counters.
module tb_csr_trap_ctrl;
  localparam int W = 64;
  localparam int S_RDATA = 0, S_TRAP = 1, S_VEC = 2, S_RET = 3, S_RDATA32 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_trap_ctrl_if #(.XLEN(64), .NUM_HPM(4)) bus ();
  csr_trap_ctrl_if #(.XLEN(32), .NUM_HPM(1)) bus32 ();

  csr_trap_ctrl #(.XLEN(64), .NUM_HPM(4), .MTVEC_RESET(64'h0), .HART_ID(64'd7)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  csr_trap_ctrl #(.XLEN(32), .NUM_HPM(1), .MTVEC_RESET(32'h0), .HART_ID(32'd0)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );

  logic [W-1:0] exp_q[$];
  int           sel_q[$];
  string        tag_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] observe(input int sel);
    case (sel)
      S_RDATA:  observe = bus.rdata;
      S_TRAP:   observe = 64'(bus.raise_trap);
      S_VEC:    observe = bus.trap_vector;
      S_RET:    observe = 64'(bus.trap_return);
      default:  observe = 64'(bus32.rdata);
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [W-1:0] v);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(v);
  endtask

  // Compare everything queued for this cycle at the falling edge, then advance one cycle.
  task automatic tick();
    @(negedge clk);
    while (exp_q.size() > 0) check(tag_q.pop_front(), observe(sel_q.pop_front()), exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_csr(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r);
    enc_csr = {a, r, f3, 5'd1, 7'h73};
  endfunction

  task automatic idle();
    bus.valid = 1'b0; bus.pc = '0; bus.inst_bits = '0; bus.is_csr = 1'b0; bus.funct3 = '0;
    bus.is_mret = 1'b0; bus.csr_addr = '0; bus.rs1_addr = '0; bus.rs1_data = '0;
    bus.expt_valid = 1'b0; bus.expt_cause = '0; bus.expt_value = '0; bus.retire = 1'b0;
    bus.hpm_event = '0;
  endtask

  task automatic idle32();
    bus32.valid = 1'b0; bus32.pc = '0; bus32.inst_bits = '0; bus32.is_csr = 1'b0; bus32.funct3 = '0;
    bus32.is_mret = 1'b0; bus32.csr_addr = '0; bus32.rs1_addr = '0; bus32.rs1_data = '0;
    bus32.expt_valid = 1'b0; bus32.expt_cause = '0; bus32.expt_value = '0; bus32.retire = 1'b0;
    bus32.hpm_event = '0; bus32.irq_meip = 1'b0; bus32.irq_msip = 1'b0; bus32.irq_mtip = 1'b0;
  endtask

  task automatic set_irqs(input logic e, input logic s, input logic t);
    bus.irq_meip = e; bus.irq_msip = s; bus.irq_mtip = t;
  endtask

  task automatic drive_csr(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r,
                           input logic [63:0] d, input logic [63:0] pc);
    idle();
    bus.valid = 1'b1; bus.is_csr = 1'b1; bus.funct3 = f3; bus.csr_addr = a;
    bus.rs1_addr = r; bus.rs1_data = d; bus.pc = pc; bus.inst_bits = enc_csr(f3, a, r);
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] exp, input string tag);
    drive_csr(3'b010, a, 5'd0, 64'h0, 64'h0);
    push_exp(tag, S_RDATA, exp);
    push_exp({tag, "_notrap"}, S_TRAP, 64'h0);
    tick();
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d, input logic [63:0] old, input string tag);
    drive_csr(3'b001, a, 5'd5, d, 64'h0);
    push_exp(tag, S_RDATA, old);
    push_exp({tag, "_notrap"}, S_TRAP, 64'h0);
    tick();
  endtask

  task automatic csr32(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r,
                       input logic [31:0] d, input logic [63:0] exp, input string tag);
    idle32();
    bus32.valid = 1'b1; bus32.is_csr = 1'b1; bus32.funct3 = f3; bus32.csr_addr = a;
    bus32.rs1_addr = r; bus32.rs1_data = d; bus32.inst_bits = enc_csr(f3, a, r);
    push_exp(tag, S_RDATA32, exp);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle(); idle32(); set_irqs(1'b0, 1'b0, 1'b0);
    bus.valid = 1'b1; bus.expt_valid = 1'b1; bus.expt_cause = 64'd5;
    push_exp("rst_trap_quiet", S_TRAP, 64'h0);
    push_exp("rst_ret_quiet", S_RET, 64'h0);
    tick();
    idle();
    tick();
    rst = 1'b0;

    rd(12'h300, 64'h1800, "rst_mstatus");
    rd(12'h305, 64'h0, "rst_mtvec");
    rd(12'h304, 64'h0, "rst_mie");

    // Interrupt entry through a vectored mtvec.
    wr(12'h305, 64'h8001, 64'h0, "wr_mtvec");
    wr(12'h304, 64'h80, 64'h0, "wr_mie");
    wr(12'h300, 64'h8, 64'h1800, "wr_mstatus");
    idle(); set_irqs(1'b0, 1'b0, 1'b1);
    tick();
    idle(); set_irqs(1'b0, 1'b0, 1'b0);
    bus.valid = 1'b1; bus.pc = 64'h100; bus.retire = 1'b1;
    push_exp("mti_trap", S_TRAP, 64'h1);
    push_exp("mti_vector", S_VEC, 64'h801C);
    push_exp("mti_not_ret", S_RET, 64'h0);
    tick();
    rd(12'h341, 64'h100, "mti_mepc");
    rd(12'h342, 64'h8000_0000_0000_0007, "mti_mcause");
    rd(12'h300, 64'h1880, "mti_mstatus");
    rd(12'hB02, 64'h0, "mti_no_retire");
    rd(12'h344, 64'h0, "mip_cleared");

    // MRET, with mepc bit 0 masked on write.
    wr(12'h341, 64'h201, 64'h100, "wr_mepc");
    rd(12'h341, 64'h200, "mepc_bit0");
    idle(); bus.valid = 1'b1; bus.is_mret = 1'b1; bus.inst_bits = 32'h3020_0073; bus.pc = 64'h500;
    push_exp("mret_raise", S_TRAP, 64'h1);
    push_exp("mret_vector", S_VEC, 64'h200);
    push_exp("mret_ret", S_RET, 64'h1);
    tick();
    idle();
    push_exp("idle_ret", S_RET, 64'h0);
    push_exp("idle_trap", S_TRAP, 64'h0);
    tick();
    rd(12'h300, 64'h1888, "mret_mstatus");

    // All three interrupts pending: MEI wins and the CSR write is dropped.
    wr(12'h304, 64'h888, 64'h80, "wr_mie_all");
    idle(); set_irqs(1'b1, 1'b1, 1'b1);
    tick();
    drive_csr(3'b001, 12'h340, 5'd5, 64'hDEAD, 64'h300);
    push_exp("prio_trap", S_TRAP, 64'h1);
    push_exp("prio_vector", S_VEC, 64'h802C);
    tick();
    idle(); set_irqs(1'b0, 1'b0, 1'b0);
    tick();
    rd(12'h342, 64'h8000_0000_0000_000B, "prio_mcause");
    rd(12'h340, 64'h0, "prio_no_write");
    rd(12'h341, 64'h300, "prio_mepc");
    rd(12'h300, 64'h1880, "prio_mstatus");

    // Synchronous exception goes to the base even in vectored mode.
    idle(); bus.valid = 1'b1; bus.pc = 64'h400;
    bus.expt_valid = 1'b1; bus.expt_cause = 64'd5; bus.expt_value = 64'h1234;
    push_exp("expt_trap", S_TRAP, 64'h1);
    push_exp("expt_vector", S_VEC, 64'h8000);
    tick();
    rd(12'h342, 64'h5, "expt_mcause");
    rd(12'h343, 64'h1234, "expt_mtval");
    rd(12'h341, 64'h400, "expt_mepc");

    // Illegal CSR accesses.
    drive_csr(3'b001, 12'hF14, 5'd5, 64'h55, 64'h600);
    push_exp("ill_ro_trap", S_TRAP, 64'h1);
    push_exp("ill_ro_vector", S_VEC, 64'h8000);
    tick();
    rd(12'h342, 64'h2, "ill_mcause");
    rd(12'h343, 64'(enc_csr(3'b001, 12'hF14, 5'd5)), "ill_mtval");
    rd(12'hF14, 64'd7, "hartid_read");
    drive_csr(3'b010, 12'h7C0, 5'd0, 64'h0, 64'h0);
    push_exp("ill_unimpl", S_TRAP, 64'h1);
    tick();
    drive_csr(3'b000, 12'h340, 5'd0, 64'h0, 64'h0);
    push_exp("ill_funct3", S_TRAP, 64'h1);
    tick();

    // Write-data forms: RS/RC with x0 do not write, zimm is zero-extended.
    wr(12'h340, 64'hA5A5, 64'h0, "wr_mscratch");
    drive_csr(3'b011, 12'h340, 5'd0, 64'hFFFF, 64'h0);
    push_exp("rc_x0_old", S_RDATA, 64'hA5A5);
    tick();
    rd(12'h340, 64'hA5A5, "rc_x0_nowrite");
    drive_csr(3'b110, 12'h340, 5'd3, 64'h0, 64'h0);
    push_exp("rsi_old", S_RDATA, 64'hA5A5);
    tick();
    rd(12'h340, 64'hA5A7, "rsi_result");
    drive_csr(3'b011, 12'h340, 5'd5, 64'h5, 64'h0);
    tick();
    rd(12'h340, 64'hA5A2, "rc_result");

    // Performance counter events.
    for (int i = 0; i < 3; i++) begin
      idle(); bus.hpm_event = 4'b0001;
      tick();
    end
    rd(12'hB03, 64'd3, "hpm3_count");
    rd(12'hB04, 64'd0, "hpm4_idle");

    // mcycle write wins, wraps, then freezes under mcountinhibit.CY.
    drive_csr(3'b001, 12'hB00, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    push_exp("mcycle_wr_notrap", S_TRAP, 64'h0);
    tick();
    rd(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, "mcycle_written");
    rd(12'hB00, 64'h0, "mcycle_wrap");
    wr(12'h320, 64'h1, 64'h0, "wr_cinh");
    rd(12'hB00, 64'h2, "mcycle_frozen_a");
    rd(12'hB00, 64'h2, "mcycle_frozen_b");
    drive_csr(3'b010, 12'h320, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    push_exp("cinh_old", S_RDATA, 64'h1);
    tick();
    rd(12'h320, 64'h7D, "cinh_mask");

    // 32-bit instance: carry from minstret into minstreth.
    idle();
    csr32(3'b001, 12'hB02, 5'd5, 32'hFFFF_FFFF, 64'h0, "m32_wr_old");
    csr32(3'b010, 12'hB02, 5'd0, 32'h0, 64'hFFFF_FFFF, "m32_lo_pre");
    idle32(); bus32.valid = 1'b1; bus32.retire = 1'b1;
    tick();
    csr32(3'b010, 12'hB02, 5'd0, 32'h0, 64'h0, "m32_lo_wrap");
    csr32(3'b010, 12'hB82, 5'd0, 32'h0, 64'h1, "m32_hi_carry");
    idle32();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
